// File: rtl/iic_slave.sv
// iic_slave: CPU-programmable IIC (I2C) slave with a four-register map.
// Bus inputs are synchronised into clk; SDA is driven open-drain via sda_oe.
module iic_slave #(
  parameter int ADDR_LSB          = 0,
  parameter int OPT_MEM_ADDR_BITS = 1
) (
  input  logic       clk,
  input  logic       reset_n,
  input  logic [7:0] addr,
  input  logic [7:0] din,
  output logic [7:0] dout,
  input  logic       wr_en,
  input  logic       rd_en,
  input  logic       scl_i,
  input  logic       sda_i,
  output logic       sda_oe
);

  localparam int SelW = OPT_MEM_ADDR_BITS + 1;

  typedef enum logic [2:0] {
    ST_IDLE, ST_ADDR, ST_ADDR_ACK, ST_RX_DATA,
    ST_RX_ACK, ST_TX_DATA, ST_TX_ACK, ST_WAIT_STOP
  } state_t;

  state_t     state_q, state_d;
  logic       scl_s1_q, scl_s1_d, scl_s2_q, scl_s2_d, scl_prev_q, scl_prev_d;
  logic       sda_s1_q, sda_s1_d, sda_s2_q, sda_s2_d, sda_prev_q, sda_prev_d;
  logic [2:0] bit_cnt_q, bit_cnt_d;
  logic [7:0] shift_q, shift_d;
  logic       ack_on_q, ack_on_d;
  logic       sda_oe_q, sda_oe_d;
  logic [7:0] dout_q, dout_d;
  logic       en_q, en_d, busy_q, busy_d, rw_q, rw_d, rxf_q, rxf_d;
  logic       txe_q, txe_d, ovr_q, ovr_d, nack_q, nack_d;
  logic [6:0] slvaddr_q, slvaddr_d;
  logic [7:0] slvtx_q, slvtx_d, slvrx_q, slvrx_d;

  logic [SelW-1:0] sel_s;
  logic            scl_rise_s, scl_fall_s, start_s, stop_s;
  logic [7:0]      byte_s, tx_byte_s, slvcon_s;
  logic            unused_s;

  assign sel_s      = addr[ADDR_LSB+OPT_MEM_ADDR_BITS:ADDR_LSB];
  assign scl_rise_s = scl_s2_q & ~scl_prev_q;
  assign scl_fall_s = ~scl_s2_q & scl_prev_q;
  // SCL must be high both before and after the SDA transition
  assign start_s    = ~sda_s2_q & sda_prev_q & scl_s2_q & scl_prev_q;
  assign stop_s     = sda_s2_q & ~sda_prev_q & scl_s2_q & scl_prev_q;
  assign byte_s     = {shift_q[6:0], sda_s2_q};
  assign tx_byte_s  = txe_q ? 8'hFF : slvtx_q;
  assign slvcon_s   = {1'b0, nack_q, ovr_q, txe_q, rxf_q, rw_q, busy_q, en_q};
  assign unused_s   = ^{addr, shift_q[7]};
  assign dout       = dout_q;
  assign sda_oe     = sda_oe_q;

  // Next-state logic: synchronisers, CPU register access, then bus FSM (bus events win)
  always_comb begin
    state_d   = state_q;
    bit_cnt_d = bit_cnt_q;
    shift_d   = shift_q;
    ack_on_d  = ack_on_q;
    sda_oe_d  = sda_oe_q;
    dout_d    = dout_q;
    en_d      = en_q;
    busy_d    = busy_q;
    rw_d      = rw_q;
    rxf_d     = rxf_q;
    txe_d     = txe_q;
    ovr_d     = ovr_q;
    nack_d    = nack_q;
    slvaddr_d = slvaddr_q;
    slvtx_d   = slvtx_q;
    slvrx_d   = slvrx_q;

    scl_s1_d   = scl_i;
    scl_s2_d   = scl_s1_q;
    scl_prev_d = scl_s2_q;
    sda_s1_d   = sda_i;
    sda_s2_d   = sda_s1_q;
    sda_prev_d = sda_s2_q;

    // CPU side: write has priority over read
    if (wr_en) begin
      case (sel_s)
        SelW'(0): begin
          en_d   = din[0];
          ovr_d  = ovr_q & din[5];
          nack_d = nack_q & din[6];
        end
        SelW'(1): slvaddr_d = din[6:0];
        SelW'(2): begin
          slvtx_d = din;
          txe_d   = 1'b0;
        end
        default: slvaddr_d = slvaddr_q;
      endcase
    end else if (rd_en) begin
      case (sel_s)
        SelW'(0): dout_d = slvcon_s;
        SelW'(1): dout_d = {1'b0, slvaddr_q};
        SelW'(2): dout_d = slvtx_q;
        SelW'(3): begin
          dout_d = slvrx_q;
          rxf_d  = 1'b0;
        end
        default: dout_d = 8'h00;
      endcase
    end else begin
      dout_d = dout_q;
    end

    // Bus side: disabled slave is held idle and never drives SDA
    if (!en_q || !en_d) begin
      state_d  = ST_IDLE;
      sda_oe_d = 1'b0;
      busy_d   = 1'b0;
      ack_on_d = 1'b0;
    end else if (stop_s) begin
      state_d  = ST_IDLE;
      sda_oe_d = 1'b0;
      busy_d   = 1'b0;
      ack_on_d = 1'b0;
    end else if (start_s) begin
      state_d   = ST_ADDR;
      bit_cnt_d = 3'd0;
      ack_on_d  = 1'b0;
    end else begin
      case (state_q)
        ST_IDLE: state_d = ST_IDLE;
        ST_ADDR: begin
          if (scl_rise_s) begin
            shift_d = byte_s;
            if (bit_cnt_q == 3'd7) begin
              if (byte_s[7:1] == slvaddr_q) begin
                rw_d     = byte_s[0];
                busy_d   = 1'b1;
                ack_on_d = 1'b0;
                state_d  = ST_ADDR_ACK;
              end else begin
                state_d = ST_WAIT_STOP;
              end
            end else begin
              bit_cnt_d = bit_cnt_q + 3'd1;
            end
          end else begin
            shift_d = shift_q;
          end
        end
        ST_ADDR_ACK: begin
          if (scl_fall_s) begin
            if (!ack_on_q) begin
              sda_oe_d = 1'b1;
              ack_on_d = 1'b1;
            end else begin
              ack_on_d  = 1'b0;
              bit_cnt_d = 3'd0;
              if (rw_q) begin
                // first TX bit goes out on the same edge that ends the ACK
                shift_d  = tx_byte_s;
                sda_oe_d = ~tx_byte_s[7];
                txe_d    = 1'b1;
                ovr_d    = ovr_d | txe_q;
                state_d  = ST_TX_DATA;
              end else begin
                sda_oe_d = 1'b0;
                state_d  = ST_RX_DATA;
              end
            end
          end else begin
            sda_oe_d = sda_oe_q;
          end
        end
        ST_RX_DATA: begin
          if (scl_rise_s) begin
            shift_d = byte_s;
            if (bit_cnt_q == 3'd7) begin
              slvrx_d  = byte_s;
              rxf_d    = 1'b1;
              ovr_d    = ovr_d | rxf_q;
              ack_on_d = 1'b0;
              state_d  = ST_RX_ACK;
            end else begin
              bit_cnt_d = bit_cnt_q + 3'd1;
            end
          end else begin
            shift_d = shift_q;
          end
        end
        ST_RX_ACK: begin
          if (scl_fall_s) begin
            if (!ack_on_q) begin
              sda_oe_d = 1'b1;
              ack_on_d = 1'b1;
            end else begin
              sda_oe_d  = 1'b0;
              ack_on_d  = 1'b0;
              bit_cnt_d = 3'd0;
              state_d   = ST_RX_DATA;
            end
          end else begin
            sda_oe_d = sda_oe_q;
          end
        end
        ST_TX_DATA: begin
          if (scl_fall_s) begin
            if (bit_cnt_q == 3'd7) begin
              sda_oe_d = 1'b0;
              ack_on_d = 1'b0;
              state_d  = ST_TX_ACK;
            end else begin
              bit_cnt_d = bit_cnt_q + 3'd1;
              shift_d   = {shift_q[6:0], 1'b0};
              sda_oe_d  = ~shift_q[6];
            end
          end else begin
            sda_oe_d = sda_oe_q;
          end
        end
        ST_TX_ACK: begin
          if (scl_rise_s) begin
            if (sda_s2_q) begin
              nack_d  = 1'b1;
              state_d = ST_WAIT_STOP;
            end else begin
              ack_on_d = 1'b1;
            end
          end else if (scl_fall_s && ack_on_q) begin
            ack_on_d  = 1'b0;
            bit_cnt_d = 3'd0;
            shift_d   = tx_byte_s;
            sda_oe_d  = ~tx_byte_s[7];
            txe_d     = 1'b1;
            ovr_d     = ovr_d | txe_q;
            state_d   = ST_TX_DATA;
          end else begin
            state_d = ST_TX_ACK;
          end
        end
        ST_WAIT_STOP: state_d = ST_WAIT_STOP;
        default: begin
          state_d  = ST_IDLE;
          sda_oe_d = 1'b0;
        end
      endcase
    end
  end

  // State and register update with asynchronous reset
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q    <= ST_IDLE;
      scl_s1_q   <= 1'b1;
      scl_s2_q   <= 1'b1;
      scl_prev_q <= 1'b1;
      sda_s1_q   <= 1'b1;
      sda_s2_q   <= 1'b1;
      sda_prev_q <= 1'b1;
      bit_cnt_q  <= 3'd0;
      shift_q    <= 8'h00;
      ack_on_q   <= 1'b0;
      sda_oe_q   <= 1'b0;
      dout_q     <= 8'h00;
      en_q       <= 1'b0;
      busy_q     <= 1'b0;
      rw_q       <= 1'b0;
      rxf_q      <= 1'b0;
      txe_q      <= 1'b1;
      ovr_q      <= 1'b0;
      nack_q     <= 1'b0;
      slvaddr_q  <= 7'd0;
      slvtx_q    <= 8'h00;
      slvrx_q    <= 8'h00;
    end else begin
      state_q    <= state_d;
      scl_s1_q   <= scl_s1_d;
      scl_s2_q   <= scl_s2_d;
      scl_prev_q <= scl_prev_d;
      sda_s1_q   <= sda_s1_d;
      sda_s2_q   <= sda_s2_d;
      sda_prev_q <= sda_prev_d;
      bit_cnt_q  <= bit_cnt_d;
      shift_q    <= shift_d;
      ack_on_q   <= ack_on_d;
      sda_oe_q   <= sda_oe_d;
      dout_q     <= dout_d;
      en_q       <= en_d;
      busy_q     <= busy_d;
      rw_q       <= rw_d;
      rxf_q      <= rxf_d;
      txe_q      <= txe_d;
      ovr_q      <= ovr_d;
      nack_q     <= nack_d;
      slvaddr_q  <= slvaddr_d;
      slvtx_q    <= slvtx_d;
      slvrx_q    <= slvrx_d;
    end
  end

endmodule

// File: tb/tb_iic_slave.sv
// tb_iic_slave: bit-banged IIC master plus CPU driver, scoreboard-checked.
module tb_iic_slave;
  localparam int Q = 10;  // quarter SCL period in clk cycles

  logic       clk = 1'b0;
  logic       reset_n;
  logic [7:0] addr, din, dout;
  logic       wr_en, rd_en, scl_i, sda_m, sda_i, sda_oe;
  int         n_vec = 0, n_mis = 0, oe_cnt = 0;
  logic [7:0] exp_q[$];
  string      tag_q[$];

  assign sda_i = sda_m & ~sda_oe;  // open-drain wired-AND

  iic_slave dut (
    .clk(clk), .reset_n(reset_n), .addr(addr), .din(din), .dout(dout),
    .wr_en(wr_en), .rd_en(rd_en), .scl_i(scl_i), .sda_i(sda_i), .sda_oe(sda_oe)
  );

  always #5 clk = ~clk;

  // count cycles in which the slave pulls SDA low
  always @(posedge clk) if (sda_oe) oe_cnt <= oe_cnt + 1;

  task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    n_vec++;
    if (obs !== exp) begin
      n_mis++;
      $display("FAIL %s: got %h, expected %h", tag, obs, exp);
    end
  endtask

  task automatic sb_push(input string tag, input logic [7:0] v);
    tag_q.push_back(tag);
    exp_q.push_back(v);
  endtask

  task automatic sb_pop(input logic [7:0] obs);
    if (exp_q.size() == 0) begin
      n_vec++;
      n_mis++;
      $display("FAIL sb_underflow: got %h, expected nothing", obs);
    end else begin
      chk(tag_q.pop_front(), obs, exp_q.pop_front());
    end
  endtask

  task automatic tick(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic cpu_write(input logic [7:0] a, input logic [7:0] d);
    addr = a; din = d; wr_en = 1'b1;
    tick(1);
    wr_en = 1'b0;
  endtask

  task automatic cpu_read(input string tag, input logic [7:0] a, input logic [7:0] exp);
    sb_push(tag, exp);
    addr = a; rd_en = 1'b1;
    tick(1);
    rd_en = 1'b0;
    sb_pop(dout);
  endtask

  task automatic bus_start();
    sda_m = 1'b1; tick(Q);
    scl_i = 1'b1; tick(Q);
    sda_m = 1'b0; tick(Q);
    scl_i = 1'b0; tick(Q);
  endtask

  task automatic bus_stop();
    sda_m = 1'b0; tick(Q);
    scl_i = 1'b1; tick(Q);
    sda_m = 1'b1; tick(Q);
  endtask

  task automatic send_bit(input logic b);
    sda_m = b; tick(Q);
    scl_i = 1'b1; tick(2 * Q);
    scl_i = 1'b0; tick(Q);
  endtask

  task automatic read_bit(output logic b);
    sda_m = 1'b1; tick(Q);
    scl_i = 1'b1; tick(Q);
    b = sda_i; tick(Q);
    scl_i = 1'b0; tick(Q);
  endtask

  task automatic wr_byte(input string tag, input logic [7:0] v, input logic exp_ack);
    logic a;
    for (int i = 7; i >= 0; i--) send_bit(v[i]);
    sb_push(tag, {7'd0, exp_ack});
    read_bit(a);
    sb_pop({7'd0, a});
  endtask

  task automatic rd_byte(input string tag, input logic [7:0] exp);
    logic [7:0] v;
    logic b;
    sb_push(tag, exp);
    for (int i = 7; i >= 0; i--) begin
      read_bit(b);
      v[i] = b;
    end
    sb_pop(v);
  endtask

  initial begin
    int c0;
    reset_n = 1'b0; scl_i = 1'b1; sda_m = 1'b1;
    addr = 8'h00; din = 8'h00; wr_en = 1'b0; rd_en = 1'b0;
    tick(3);
    chk("rst_dout", dout, 8'h00);
    chk("rst_oe", {7'd0, sda_oe}, 8'h00);
    reset_n = 1'b1;
    tick(2);
    cpu_read("rst_slvcon", 8'd0, 8'h10);
    cpu_read("rst_slvaddr", 8'd1, 8'h00);

    // write transfer: address 0x42, one data byte
    cpu_write(8'd1, 8'h42);
    cpu_write(8'd0, 8'h01);
    bus_start();
    wr_byte("w_addr_ack", 8'h84, 1'b0);
    cpu_read("w_busy", 8'd0, 8'h13);
    wr_byte("w_data_ack", 8'h5A, 1'b0);
    bus_stop();
    tick(4);
    cpu_read("w_con_after", 8'd0, 8'h19);
    cpu_read("w_slvrx", 8'd3, 8'h5A);
    cpu_read("w_rxf_clr", 8'd0, 8'h11);

    // foreign address: never driven, RXF untouched
    c0 = oe_cnt;
    bus_start();
    wr_byte("nm_addr_nack", 8'h86, 1'b1);
    wr_byte("nm_data_nack", 8'h77, 1'b1);
    chk("nm_oe_never", 8'(oe_cnt - c0), 8'h00);
    cpu_read("nm_con", 8'd0, 8'h11);
    bus_stop();
    tick(4);
    cpu_read("nm_slvrx", 8'd3, 8'h5A);

    // read transfer ending in NACK
    cpu_write(8'd2, 8'hC3);
    cpu_read("r_txe_clr", 8'd0, 8'h01);
    bus_start();
    wr_byte("r_addr_ack", 8'h85, 1'b0);
    rd_byte("r_data", 8'hC3);
    send_bit(1'b1);
    bus_stop();
    tick(4);
    cpu_read("r_con_nack", 8'd0, 8'h55);
    cpu_write(8'd0, 8'h01);
    cpu_read("r_con_clr", 8'd0, 8'h15);

    // overrun: two bytes without reading SLVRX
    bus_start();
    wr_byte("o_addr_ack", 8'h84, 1'b0);
    wr_byte("o_d1_ack", 8'h11, 1'b0);
    wr_byte("o_d2_ack", 8'h22, 1'b0);
    bus_stop();
    tick(4);
    cpu_read("o_con", 8'd0, 8'h39);
    cpu_read("o_slvrx", 8'd3, 8'h22);
    cpu_read("o_rxf_clr", 8'd0, 8'h31);

    // clearing EN while the address ACK is driven
    bus_start();
    for (int i = 7; i >= 0; i--) send_bit(dut_addr_bit(i));
    chk("en_ack_on", {7'd0, sda_oe}, 8'h01);
    cpu_write(8'd0, 8'h00);
    chk("en_oe_rel", {7'd0, sda_oe}, 8'h00);
    bus_stop();
    cpu_write(8'd0, 8'h01);
    tick(2);
    cpu_read("en_con", 8'd0, 8'h11);

    // write then repeated START into a read
    cpu_write(8'd2, 8'hA5);
    bus_start();
    wr_byte("rs_waddr_ack", 8'h84, 1'b0);
    wr_byte("rs_wdata_ack", 8'h33, 1'b0);
    bus_start();
    wr_byte("rs_raddr_ack", 8'h85, 1'b0);
    rd_byte("rs_rdata", 8'hA5);
    cpu_read("rs_con_mid", 8'd0, 8'h1F);
    send_bit(1'b0);
    rd_byte("rs_rdata_empty", 8'hFF);
    send_bit(1'b1);
    bus_stop();
    tick(4);
    cpu_read("rs_con_end", 8'd0, 8'h7D);
    cpu_read("rs_slvrx", 8'd3, 8'h33);

    // reset during the 4th data bit
    bus_start();
    wr_byte("rr_addr_ack", 8'h84, 1'b0);
    send_bit(1'b1); send_bit(1'b0); send_bit(1'b1);
    sda_m = 1'b0; tick(Q);
    scl_i = 1'b1; tick(Q);
    #2 reset_n = 1'b0;
    #1 chk("rr_oe", {7'd0, sda_oe}, 8'h00);
    tick(1);
    reset_n = 1'b1;
    tick(2);
    cpu_read("rr_con", 8'd0, 8'h10);
    cpu_read("rr_slvaddr", 8'd1, 8'h00);
    cpu_read("rr_slvrx", 8'd3, 8'h00);
    cpu_read("rr_slvtx", 8'd2, 8'h00);
    scl_i = 1'b0; tick(Q);
    bus_stop();
    cpu_write(8'd1, 8'h42);
    cpu_write(8'd0, 8'h01);
    bus_start();
    wr_byte("rr_new_ack", 8'h84, 1'b0);
    wr_byte("rr_new_data", 8'h3C, 1'b0);
    bus_stop();
    tick(4);
    cpu_read("rr_new_rx", 8'd3, 8'h3C);

    chk("sb_drain", 8'(exp_q.size()), 8'h00);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_mis);
    $finish;
  end

  // address byte 0x84 (0x42, write) bit by bit
  function automatic logic dut_addr_bit(input int i);
    logic [7:0] a;
    a = 8'h84;
    return a[i];
  endfunction

endmodule

// File: doc/iic_slave.md
IIC_SLAVE -- requirements
Module: iic_slave

Interface
REQ-001 Parameter ADDR_LSB, default 0: lowest CPU address bit used for register select.
REQ-002 Parameter OPT_MEM_ADDR_BITS, default 1: register select is addr[ADDR_LSB+OPT_MEM_ADDR_BITS:ADDR_LSB] (4 registers).
REQ-003 clk  input  1  single system clock; all logic SHALL be clocked on the rising edge.
REQ-004 reset_n  input  1  asynchronous, active-low reset.
REQ-005 addr  input  8  CPU register address.
REQ-006 din  input  8  CPU write data.
REQ-007 dout  output  8  CPU read data, registered.
REQ-008 wr_en  input  1  CPU write strobe, one clk per write.
REQ-009 rd_en  input  1  CPU read strobe, one clk per read.
REQ-010 scl_i  input  1  IIC clock from bus (asynchronous).
REQ-011 sda_i  input  1  IIC data from bus (asynchronous).
REQ-012 sda_oe  output  1  1 = pull SDA low; 0 = release (open drain).

Function
REQ-013 Register map: 0 SLVCON, 1 SLVADDR (bits[6:0] own address), 2 SLVTX, 3 SLVRX.
REQ-014 SLVCON bits: [0] EN (rw), [1] BUSY (ro), [2] RW of current transfer (ro), [3] RXF (ro), [4] TXE (ro), [5] OVR (rw, write 0 clears), [6] NACK (rw, write 0 clears), [7] reserved, reads 0.
REQ-015 Writes take effect the clk after wr_en; dout SHALL update the clk after rd_en; wr_en has priority when both are asserted.
REQ-016 scl_i and sda_i SHALL pass through a 2-flop synchronizer, with edges detected on the synchronized values; clk SHALL be at least 16x SCL frequency.
REQ-017 START = synchronized SDA falling while SCL high; STOP = SDA rising while SCL high; both are recognised in every state, including during data phases.
REQ-018 States: IDLE, ADDR, ADDR_ACK, RX_DATA, RX_ACK, TX_DATA, TX_ACK, WAIT_STOP.
REQ-019 IDLE -> ADDR on START when EN=1; with EN=0, all bus events are ignored and sda_oe stays 0.
REQ-020 ADDR: shift 8 bits MSB-first on SCL rising edges; after the 8th bit, compare bits[7:1] with SLVADDR[6:0].
REQ-021 Match: latch RW=bit0, set BUSY, assert sda_oe on the next SCL falling edge for one SCL period (ADDR_ACK); mismatch -> WAIT_STOP with sda_oe=0.
REQ-022 After ADDR_ACK: RW=0 -> RX_DATA; RW=1 -> TX_DATA, loading the SLVTX shift register at the SCL falling edge ending the ACK.
REQ-023 RX_DATA: shift 8 bits on SCL rising edges, then on byte completion: SLVRX <= byte, RXF <= 1, and OVR <= 1 if RXF was already 1 (new byte overwrites); always ACK (RX_ACK), then return to RX_DATA.
REQ-024 Reading SLVRX SHALL clear RXF the clk after rd_en, unless a byte completes in that same clk, in which case RXF stays 1.
REQ-025 TX_DATA: set sda_oe = ~bit on each SCL falling edge, MSB first; release after the 8th bit; if TXE=1 at load time, send 8'hFF and set OVR.
REQ-026 Each loaded SLVTX byte SHALL set TXE=1; writing SLVTX clears TXE.
REQ-027 TX_ACK: sample SDA on the SCL rising edge; low -> reload and continue TX_DATA; high -> set NACK, go to WAIT_STOP.
REQ-028 A repeated START in any state SHALL re-enter ADDR; a STOP in any state SHALL go to IDLE, clear BUSY and release sda_oe.
REQ-029 sda_oe SHALL only change on synchronized SCL falling edges or on STOP/reset/EN clear.
REQ-030 Clearing EN mid-transfer SHALL release sda_oe within one clk and force IDLE.

Reset
REQ-031 reset_n low SHALL asynchronously set state=IDLE, sda_oe=0, dout=0, SLVCON=8'h10 (TXE=1), SLVADDR=0, SLVTX=0, SLVRX=0, and synchronizers to 1.
REQ-032 Reset mid-transfer SHALL release SDA immediately; after reset, the block waits for a new START.

Verification
REQ-033 EN=1, SLVADDR=0x42; master writes addr byte 0x84, then data 0x5A, then STOP -> ACK on both 9th clocks, SLVRX=0x5A, RXF=1, BUSY=0 after STOP.
REQ-034 Master sends addr byte 0x86 (address 0x43) -> sda_oe never asserted; state WAIT_STOP; RXF unchanged.
REQ-035 SLVTX=0xC3; master reads from 0x42 (byte 0x85) with NACK -> SDA bits 1100_0011, TXE=1, NACK=1.
REQ-036 Two writes 0x11, 0x22 without reading SLVRX -> SLVRX=0x22, OVR=1; then a CPU read -> dout=0x22, RXF=0.
REQ-037 Write followed by repeated START into a read -> second address ACKed, RW=1, TX data driven.
REQ-038 reset_n pulse during the 4th RX bit -> sda_oe=0 immediately, registers at reset values, next valid transaction ACKed.
